// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared mode encodings for the universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/usr_bit.sv
`default_nettype none
// ============================================================================
// Module      : usr_bit
// Description : Single register cell; 4:1 next-value mux, sync rst/pst.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_bit
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pst,
    input  logic [1:0] sel,
    input  logic       shr_in,   // value arriving from the higher neighbour
    input  logic       shl_in,   // value arriving from the lower neighbour
    input  logic       ld,
    output logic       q,
    output logic       qb
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (pst) begin
            r_q <= 1'b1;
        end else begin
            case (mode_t'(sel))
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= shr_in;
                MODE_SHL:  r_q <= shl_in;
                MODE_LOAD: r_q <= ld;
            endcase
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;

endmodule
`default_nettype wire

// File: rtl/usr_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : usr_shift_reg
// Description : Universal shift register with saturating shift counter.
//               Optional rotate input enabled by macro USR_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_r,
    input  logic             si_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so_r,
    output logic             so_l,
    output logic [CNT_W-1:0] cnt,
    output logic             full_shift
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WIDTH);

    logic             w_ser_r;
    logic             w_ser_l;
    logic [WIDTH-1:0] w_shr_src;
    logic [WIDTH-1:0] w_shl_src;
    logic [CNT_W-1:0] r_cnt;

`ifdef USR_ROTATE_EN
    assign w_ser_r = rot ? q[0]       : si_r;
    assign w_ser_l = rot ? q[WIDTH-1] : si_l;
`else
    assign w_ser_r = si_r;
    assign w_ser_l = si_l;
`endif

    // Per-bit neighbour values, with the serial inputs filling the ends
    assign w_shr_src = {w_ser_r, q[WIDTH-1:1]};
    assign w_shl_src = {q[WIDTH-2:0], w_ser_l};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            usr_bit u_bit (
                .clk    (clk),
                .rst    (rst),
                .pst    (pst),
                .sel    (mode),
                .shr_in (w_shr_src[i]),
                .shl_in (w_shl_src[i]),
                .ld     (d[i]),
                .q      (q[i]),
                .qb     (qb[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || pst) begin
            r_cnt <= '0;
        end else begin
            case (mode_t'(mode))
                MODE_SHR, MODE_SHL: begin
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
                end
                MODE_LOAD: r_cnt <= '0;
                default:   r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt        = r_cnt;
    assign full_shift = (r_cnt == c_cnt_max);
    assign so_r       = q[0];
    assign so_l       = q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_usr_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_shift_reg
// Description : Scoreboard bench for usr_shift_reg (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_shift_reg;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       si_r = 1'b0;
    logic       si_l = 1'b0;
    logic       rot = 1'b0;
    logic [7:0] q, qb;
    logic       so_r, so_l, full_shift;
    logic [3:0] cnt;

    int   vecs = 0;
    int   miss = 0;
    exp_t m = '0;
    exp_t e;
    exp_t sb[$];

    always #5 clk = ~clk;

    usr_shift_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pst        (pst),
        .mode       (mode),
        .d          (d),
        .si_r       (si_r),
        .si_l       (si_l),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .q          (q),
        .qb         (qb),
        .so_r       (so_r),
        .so_l       (so_l),
        .cnt        (cnt),
        .full_shift (full_shift)
    );

    function automatic exp_t model_next(exp_t s, logic r, logic p, logic [1:0] md,
                                        logic [7:0] dd, logic sr, logic sl, logic rt);
        exp_t n = s;
        logic [3:0] inc = (s.cnt < 4'd8) ? s.cnt + 4'd1 : 4'd8;
        if (r) begin
            n.q = 8'h00; n.cnt = 4'd0;
        end else if (p) begin
            n.q = 8'hFF; n.cnt = 4'd0;
        end else if (md == 2'b01) begin
            n.q = {(rt ? s.q[0] : sr), s.q[7:1]}; n.cnt = inc;
        end else if (md == 2'b10) begin
            n.q = {s.q[6:0], (rt ? s.q[7] : sl)}; n.cnt = inc;
        end else if (md == 2'b11) begin
            n.q = dd; n.cnt = 4'd0;
        end
        return n;
    endfunction

    // Drive one edge; inputs that the mode ignores are driven to X
    task automatic step(input logic r, input logic p, input logic [1:0] md,
                        input logic [7:0] dd, input logic sr, input logic sl);
        rst  = r;
        pst  = p;
        mode = md;
        d    = (md == 2'b11) ? dd : 8'hxx;
        si_r = (md == 2'b01) ? sr : 1'bx;
        si_l = (md == 2'b10) ? sl : 1'bx;
`ifdef USR_ROTATE_EN
        m = model_next(m, r, p, md, dd, sr, sl, rot);
`else
        m = model_next(m, r, p, md, dd, sr, sl, 1'b0);
`endif
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
        e = sb.pop_front();
        vecs++;
        if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)})
            begin miss++; $display("FAIL reset: q=%h qb=%h cnt=%0d fs=%b want q=%h cnt=%0d", q, qb, cnt, full_shift, e.q, e.cnt); end
        vecs++;
        if (q !== 8'h00 || qb !== 8'hFF || cnt !== 4'd0 || full_shift !== 1'b0)
            begin miss++; $display("FAIL reset_const: q=%h qb=%h cnt=%0d fs=%b want 00/FF/0/0", q, qb, cnt, full_shift); end
        rst = 1'b0; pst = 1'b0;
    endtask

    task automatic test_shift_right();
        step(1'b0, 1'b0, 2'b11, 8'h96, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)})
                begin miss++; $display("FAIL shr[%0d]: q=%h cnt=%0d so_r=%b want q=%h cnt=%0d", i, q, cnt, so_r, e.q, e.cnt); end
        end
        vecs++;
        if (q !== 8'hF2 || so_r !== 1'b0 || cnt !== 4'd3)
            begin miss++; $display("FAIL shr_const: q=%h so_r=%b cnt=%0d want F2/0/3", q, so_r, cnt); end
    endtask

    task automatic test_shift_left_sat();
        step(1'b0, 1'b0, 2'b11, 8'h81, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)})
                begin miss++; $display("FAIL shl[%0d]: q=%h cnt=%0d fs=%b want q=%h cnt=%0d", i, q, cnt, full_shift, e.q, e.cnt); end
            if (i >= 8) begin
                vecs++;
                if (q !== 8'h00 || cnt !== 4'd8 || full_shift !== 1'b1)
                    begin miss++; $display("FAIL shl_sat[%0d]: q=%h cnt=%0d fs=%b want 00/8/1", i, q, cnt, full_shift); end
            end
        end
    endtask

    task automatic test_preset_hold();
        step(1'b0, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0);
        void'(sb.pop_front());
        repeat (4) begin
            step(1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        vecs++;
        if (cnt !== 4'd4) begin miss++; $display("FAIL pre_cnt4: cnt=%0d want 4", cnt); end
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)} || q !== 8'hFF || cnt !== 4'd0)
                begin miss++; $display("FAIL preset_hold[%0d]: q=%h cnt=%0d want q=FF cnt=0", i, q, cnt); end
        end
    endtask

    task automatic test_load_on_sat();
        step(1'b0, 1'b0, 2'b11, 8'hC3, 1'b0, 1'b0);
        void'(sb.pop_front());
        repeat (7) begin
            step(1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1);
            void'(sb.pop_front());
        end
        step(1'b0, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0);
        e = sb.pop_front();
        vecs++;
        if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)} || q !== 8'h3C || cnt !== 4'd0 || full_shift !== 1'b0)
            begin miss++; $display("FAIL load_on_sat: q=%h cnt=%0d fs=%b want 3C/0/0", q, cnt, full_shift); end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        rot = 1'b1;
        step(1'b0, 1'b0, 2'b11, 8'h01, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)})
                begin miss++; $display("FAIL rot[%0d]: q=%h cnt=%0d want q=%h cnt=%0d", i, q, cnt, e.q, e.cnt); end
        end
        vecs++;
        if (q !== 8'h80 || cnt !== 4'd8)
            begin miss++; $display("FAIL rot_const: q=%h cnt=%0d want 80/8", q, cnt); end
        rot = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic r, p;
        logic [1:0] md;
        for (int i = 0; i < 60; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 14) == 0);
            md = 2'($urandom_range(0, 3));
`ifdef USR_ROTATE_EN
            rot = 1'($urandom_range(0, 1));
`endif
            step(r, p, md, 8'($urandom), 1'($urandom), 1'($urandom));
            e = sb.pop_front();
            vecs++;
            if ({q, qb, so_r, so_l, cnt, full_shift} !== {e.q, ~e.q, e.q[0], e.q[7], e.cnt, (e.cnt == 4'd8)})
                begin miss++; $display("FAIL b2b[%0d]: q=%h qb=%h cnt=%0d fs=%b want q=%h cnt=%0d", i, q, qb, cnt, full_shift, e.q, e.cnt); end
        end
        rot = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_shift_right();
        test_shift_left_sat();
        test_preset_hold();
        test_load_on_sat();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
